// File: rtl/sid_voice_out.sv
// SID per-voice waveform generator and envelope multiplier.
// Time-multiplexed, one voice per clock, fixed one-cycle latency.
module sid_voice_out (
  input  logic        clk,
  input  logic        rst,
  input  logic        model,
  input  logic [23:0] acc,
  input  logic [22:0] noise,
  input  logic [11:0] pw,
  input  logic [3:0]  wave_sel,
  input  logic        test,
  input  logic        ring_mod,
  input  logic        ring_msb,
  input  logic [7:0]  env,
  output logic [7:0]  osc_o,
  output logic [23:0] voice_o
);

  localparam int unsigned WAVE_W = 12;
  localparam int unsigned CTR_W  = 14;
  localparam int unsigned PROD_W = 23;
  localparam int unsigned OUT_W  = 24;

  logic [WAVE_W-1:0]        saw;
  logic [WAVE_W-1:0]        tri_w;
  logic [WAVE_W-1:0]        pulse;
  logic [WAVE_W-1:0]        nse;
  logic [WAVE_W-1:0]        wave;
  logic                     tmsb;
  logic signed [CTR_W-1:0]  centered;
  logic signed [PROD_W-1:0] prod;

  // Waveform selection and DC-offset-corrected envelope multiply
  always_comb begin
    saw   = acc[23:12];
    tmsb  = acc[23] ^ (ring_mod & ~ring_msb);
    tri_w = {acc[22:12] ^ {11{tmsb}}, 1'b0};
    pulse = (test || (saw >= pw)) ? 12'hFFF : 12'h000;
    nse   = {noise[22], noise[20], noise[16], noise[13],
             noise[11], noise[7],  noise[4],  noise[2], 4'b0000};

    wave = 12'hFFF;
    if (wave_sel[0]) wave = wave & tri_w;
    if (wave_sel[1]) wave = wave & saw;
    if (wave_sel[2]) wave = wave & pulse;
    if (wave_sel[3]) wave = wave & nse;
    if (wave_sel == 4'b0000) wave = 12'h000;

    centered = $signed({2'b00, wave}) - (model ? 14'sd2048 : 14'sd896);
    prod     = PROD_W'(centered) * PROD_W'($signed({1'b0, env}));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osc_o   <= 8'h00;
      voice_o <= 24'h000000;
    end else begin
      osc_o   <= wave[11:4];
      voice_o <= OUT_W'(prod);
    end
  end

endmodule

// File: tb/tb_sid_voice_out.sv
// Scoreboard bench for sid_voice_out: expected results are queued as
// stimulus is driven and compared one clock later.
module tb_sid_voice_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        model;
  logic [23:0] acc;
  logic [22:0] noise;
  logic [11:0] pw;
  logic [3:0]  wave_sel;
  logic        test;
  logic        ring_mod;
  logic        ring_msb;
  logic [7:0]  env;
  logic [7:0]  osc_o;
  logic [23:0] voice_o;

  typedef struct {
    logic [7:0]  osc;
    logic [23:0] voice;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  sid_voice_out dut (
    .clk      (clk),
    .rst      (rst),
    .model    (model),
    .acc      (acc),
    .noise    (noise),
    .pw       (pw),
    .wave_sel (wave_sel),
    .test     (test),
    .ring_mod (ring_mod),
    .ring_msb (ring_msb),
    .env      (env),
    .osc_o    (osc_o),
    .voice_o  (voice_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent integer model of the voice datapath
  function automatic exp_t ref_out(input logic m, input logic [23:0] a, input logic [22:0] n,
                                   input logic [11:0] p, input logic [3:0] ws, input logic t,
                                   input logic rm, input logic rs, input logic [7:0] e);
    exp_t r;
    int   taps [8];
    int   top, w, v, tri_v, pul, nz;
    bit   tm;
    taps = '{22, 20, 16, 13, 11, 7, 4, 2};
    top  = int'(a[23:12]);
    tm   = a[23] ^ (rm && !rs);
    tri_v = tm ? (((~top) & 'h7FF) * 2) : ((top & 'h7FF) * 2);
    pul  = (t || top >= int'(p)) ? 4095 : 0;
    nz   = 0;
    for (int i = 0; i < 8; i++) if (n[taps[i]]) nz |= (1 << (11 - i));
    w = 4095;
    if (ws[0]) w &= tri_v;
    if (ws[1]) w &= top;
    if (ws[2]) w &= pul;
    if (ws[3]) w &= nz;
    if (ws == 4'b0000) w = 0;
    v = (w - (m ? 2048 : 896)) * int'(e);
    r.osc   = 8'(w >> 4);
    r.voice = 24'(v);
    return r;
  endfunction

  task automatic drive(input logic m, input logic [23:0] a, input logic [22:0] n,
                       input logic [11:0] p, input logic [3:0] ws, input logic t,
                       input logic rm, input logic rs, input logic [7:0] e);
    model = m; acc = a; noise = n; pw = p; wave_sel = ws;
    test = t; ring_mod = rm; ring_msb = rs; env = e;
  endtask

  task automatic apply(input logic m, input logic [23:0] a, input logic [22:0] n,
                       input logic [11:0] p, input logic [3:0] ws, input logic t,
                       input logic rm, input logic rs, input logic [7:0] e);
    drive(m, a, n, p, ws, t, rm, rs, e);
    sb.push_back(ref_out(m, a, n, p, ws, t, rm, rs, e));
  endtask

  // Queue hand-computed expected values for the headline cases
  task automatic apply_k(input logic m, input logic [23:0] a, input logic [22:0] n,
                         input logic [11:0] p, input logic [3:0] ws, input logic t,
                         input logic rm, input logic rs, input logic [7:0] e,
                         input logic [7:0] k_osc, input logic [23:0] k_voice);
    exp_t r;
    drive(m, a, n, p, ws, t, rm, rs, e);
    r.osc = k_osc;
    r.voice = k_voice;
    sb.push_back(r);
  endtask

  // One clock edge, then compare the oldest pending expectation
  task automatic step(input string tag);
    exp_t r;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      r = sb.pop_front();
      check({tag, "_osc"}, 32'(osc_o), 32'(r.osc));
      check({tag, "_voice"}, 32'(voice_o), 32'(r.voice));
    end
  endtask

  initial begin
    drive(1'b1, 24'h5A5A5A, 23'h3C3C3C, 12'h123, 4'b1111, 1'b1, 1'b1, 1'b0, 8'h77);
    #2;
    check("rst_osc", 32'(osc_o), 32'h0);
    check("rst_voice", 32'(voice_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Sawtooth after reset release
    apply_k(1'b1, 24'hABC000, 23'h0, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hAB, 24'd178500);
    step("saw");

    // Pulse and TEST
    apply_k(1'b1, 24'h7FF000, 23'h0, 12'h800, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hFF,
            8'h00, 24'(-522240));
    step("pulse_lo");
    apply(1'b1, 24'h800000, 23'h0, 12'h800, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hFF);
    step("pulse_hi");
    apply(1'b1, 24'h000000, 23'h0, 12'h800, 4'b0100, 1'b1, 1'b0, 1'b0, 8'hFF);
    step("pulse_test");
    apply(1'b0, 24'h000000, 23'h0, 12'h000, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h80);
    step("pw_zero");
    apply(1'b1, 24'hFFE000, 23'h0, 12'hFFF, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hFF);
    step("pw_max_lo");
    apply(1'b1, 24'hFFF000, 23'h0, 12'hFFF, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hFF);
    step("pw_max_hi");

    // Triangle and ring modulation
    apply_k(1'b1, 24'h800000, 23'h0, 12'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h01, 8'hFF, 24'd2046);
    step("tri");
    apply(1'b1, 24'h800000, 23'h0, 12'h0, 4'b0001, 1'b0, 1'b1, 1'b1, 8'h01);
    step("ring_msb1");
    apply_k(1'b1, 24'h800000, 23'h0, 12'h0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 24'(-2048));
    step("ring_msb0");

    // Noise and combinations
    apply_k(1'b1, 24'h0, 23'h7FFFFF, 12'h0, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 24'd0);
    step("noise");
    apply(1'b0, 24'h0F0000, 23'h7FFFFF, 12'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 8'h10);
    step("noise_saw");

    // Model offsets and envelope
    apply_k(1'b0, 24'h0, 23'h0, 12'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 24'hFC8380);
    step("off6581");
    apply_k(1'b1, 24'hFFF000, 23'h0, 12'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 24'(-522240));
    step("off8580");
    apply_k(1'b1, 24'hFFF000, 23'h7FFFFF, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 24'd0);
    step("env0");
    apply_k(1'b0, 24'hFFF000, 23'h0, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 24'd815745);
    step("max6581");

    // Back-to-back voices with alternating model
    for (int i = 0; i < 6; i++) begin
      apply(1'(i), 24'($urandom), 23'($urandom), 12'($urandom), 4'($urandom), 1'b0,
            1'($urandom), 1'($urandom), 8'($urandom));
      step("b2b");
    end

    // Reset mid-stream drops the pending sample at once
    apply(1'b1, 24'hFFF000, 23'h0, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'hFF);
    step("pre_rst");
    apply(1'b0, 24'hC00000, 23'h0, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_osc", 32'(osc_o), 32'h0);
    check("midrst_voice", 32'(voice_o), 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 24'hC00000, 23'h0, 12'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 8'hFF);
    step("post_rst");

    // Random sweep
    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom), 24'($urandom), 23'($urandom), 12'($urandom), 4'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
